// File: rtl/core_ctrl_pkg.sv
// Shared types for the host-side core controller: opcodes, response status and FSM states.
// CORE_CTRL_TIMEOUT_EN (see core_host_ctrl) adds the RUN timeout; TIMEOUT aliases ABORT's code.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        WRITE_INSN = 3'd0,
        WRITE_DATA = 3'd1,
        READ_DATA  = 3'd2,
        RUN        = 3'd3,
        STOP       = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        OK    = 2'd0,
        HALT  = 2'd1,
        ABORT = 2'd2,
        ERR   = 2'd3
    } status_t;

    // Host tells TIMEOUT from ABORT by comparing rsp_data with the timeout it asked for.
    localparam status_t TIMEOUT = ABORT;

    typedef enum logic [2:0] {
        IDLE,
        WR_INSN,
        WR_DATA,
        RD_WAIT,
        RST_CORE,
        RUNNING,
        RESP
    } state_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/core_ctrl_cycle_counter.sv
// Run-cycle counter: synchronous clear, saturating increment, and timeout compare.
// A zero timeout_i never matches; the top ties it to zero unless CORE_CTRL_TIMEOUT_EN is defined.
module core_ctrl_cycle_counter
    import core_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [31:0] timeout_i,
    output logic [31:0] count_o,
    output logic        timeout_hit_o
);

    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CNT_MAX)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o       = count_q;
    assign timeout_hit_o = (timeout_i != '0) && (count_q == timeout_i);

endmodule

// File: rtl/core_host_ctrl.sv
// Host command controller for a small core: loads instruction/data memory, runs the core, reports.
// Define CORE_CTRL_TIMEOUT_EN to honour the RUN timeout carried in cmd_data.
module core_host_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int READ_LAT         = 2,
    parameter int RUN_RESET_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic [31:0] rsp_data,
    output logic        core_reset,
    output logic        run,
    output logic [31:0] insn_addr,
    output logic [31:0] insn_din,
    output logic        insn_we,
    output logic [31:0] data_addr,
    output logic [31:0] data_din,
    output logic        data_we,
    output logic        data_oe,
    input  logic [31:0] data_q,
    input  logic        halt_mon
);

    localparam logic [3:0] RD_LAST  = 4'(READ_LAT - 1);
    localparam logic [3:0] RST_LAST = 4'(RUN_RESET_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    status_t     status_q, status_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] insn_addr_q, insn_addr_d, insn_din_q, insn_din_d;
    logic [31:0] data_addr_q, data_addr_d, data_din_q, data_din_d;
    logic        core_reset_q, core_reset_d;
    logic        cnt_clr, cnt_en, timeout_hit;
    logic [31:0] count, timeout_val;

`ifdef CORE_CTRL_TIMEOUT_EN
    logic [31:0] timeout_q, timeout_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_q <= '0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout_val = timeout_q;
`else
    assign timeout_val = '0;
`endif

    core_ctrl_cycle_counter u_cnt (
        .clk           (clk),
        .reset_n       (reset_n),
        .clr_i         (cnt_clr),
        .en_i          (cnt_en),
        .timeout_i     (timeout_val),
        .count_o       (count),
        .timeout_hit_o (timeout_hit)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        status_d    = status_q;
        rdata_d     = rdata_q;
        insn_addr_d = insn_addr_q;
        insn_din_d  = insn_din_q;
        data_addr_d = data_addr_q;
        data_din_d  = data_din_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
`ifdef CORE_CTRL_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    phase_d = '0;
                    case (cmd_op)
                        WRITE_INSN: begin
                            state_d     = WR_INSN;
                            insn_addr_d = cmd_addr;
                            insn_din_d  = cmd_data;
                        end
                        WRITE_DATA: begin
                            state_d     = WR_DATA;
                            data_addr_d = cmd_addr;
                            data_din_d  = cmd_data;
                        end
                        READ_DATA: begin
                            state_d     = RD_WAIT;
                            data_addr_d = cmd_addr;
                        end
                        RUN: begin
                            state_d = RST_CORE;
`ifdef CORE_CTRL_TIMEOUT_EN
                            timeout_d = cmd_data;
`endif
                        end
                        default: begin
                            state_d  = RESP;
                            status_d = ERR;
                            rdata_d  = '0;
                        end
                    endcase
                end
            end
            WR_INSN, WR_DATA: begin
                state_d  = RESP;
                status_d = OK;
                rdata_d  = '0;
            end
            RD_WAIT: begin
                phase_d = phase_q + 4'd1;
                if (phase_q == RD_LAST) begin
                    state_d  = RESP;
                    status_d = OK;
                    rdata_d  = data_q;
                end
            end
            RST_CORE: begin
                phase_d = phase_q + 4'd1;
                if (phase_q == RST_LAST) begin
                    state_d = RUNNING;
                    cnt_clr = 1'b1;
                end
            end
            RUNNING: begin
                // Halt outranks timeout, which outranks a host STOP; other opcodes are swallowed.
                cnt_en = 1'b1;
                if (halt_mon) begin
                    state_d  = RESP;
                    status_d = HALT;
                    rdata_d  = count;
                end else if (timeout_hit) begin
                    state_d  = RESP;
                    status_d = TIMEOUT;
                    rdata_d  = count;
                end else if (cmd_valid && (cmd_op == STOP)) begin
                    state_d  = RESP;
                    status_d = ABORT;
                    rdata_d  = count;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        core_reset_d = (state_d == RST_CORE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            status_q     <= OK;
            rdata_q      <= '0;
            insn_addr_q  <= '0;
            insn_din_q   <= '0;
            data_addr_q  <= '0;
            data_din_q   <= '0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            status_q     <= status_d;
            rdata_q      <= rdata_d;
            insn_addr_q  <= insn_addr_d;
            insn_din_q   <= insn_din_d;
            data_addr_q  <= data_addr_d;
            data_din_q   <= data_din_d;
            core_reset_q <= core_reset_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE) || (state_q == RUNNING);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_status = status_q;
    assign rsp_data   = rdata_q;
    assign core_reset = core_reset_q;
    assign run        = (state_q == RUNNING);
    assign insn_we    = (state_q == WR_INSN);
    assign data_we    = (state_q == WR_DATA);
    assign data_oe    = (state_q == RD_WAIT);
    assign insn_addr  = insn_addr_q;
    assign insn_din   = insn_din_q;
    assign data_addr  = data_addr_q;
    assign data_din   = data_din_q;

endmodule

// File: tb/tb_core_host_ctrl.sv
// Bench for core_host_ctrl: directed scenarios then random commands against a transaction-level model.
// Expectations follow CORE_CTRL_TIMEOUT_EN when it is defined for the build.
module tb_core_host_ctrl;
    import core_ctrl_pkg::*;

    localparam int READ_LAT         = 2;
    localparam int RUN_RESET_CYCLES = 2;
`ifdef CORE_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_data;
    logic        core_reset, run;
    logic [31:0] insn_addr, insn_din, data_addr, data_din;
    logic        insn_we, data_we, data_oe;
    logic [31:0] data_q = 32'hBAD0_BAD0;
    logic        halt_mon = 1'b0;

    int checks = 0;
    int failures = 0;

    // environment memories written by DUT strobes; shadows written by the stimulus
    logic [31:0] data_env [logic [31:0]];
    logic [31:0] insn_env [logic [31:0]];
    logic [31:0] data_shadow [logic [31:0]];
    int n_insn_we = 0, n_data_we = 0, n_data_oe = 0, oe_run = 0, n_viol = 0;

    core_host_ctrl #(.READ_LAT(READ_LAT), .RUN_RESET_CYCLES(RUN_RESET_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_data(rsp_data),
        .core_reset(core_reset), .run(run),
        .insn_addr(insn_addr), .insn_din(insn_din), .insn_we(insn_we),
        .data_addr(data_addr), .data_din(data_din), .data_we(data_we), .data_oe(data_oe),
        .data_q(data_q), .halt_mon(halt_mon)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return data_env.exists(a) ? data_env[a] : dflt(a);
    endfunction

    always @(posedge clk) begin
        if (insn_we) begin
            n_insn_we++;
            insn_env[insn_addr] = insn_din;
        end
        if (data_we) begin
            n_data_we++;
            data_env[data_addr] = data_din;
        end
        if (data_oe) begin
            n_data_oe++;
            oe_run++;
        end else begin
            oe_run = 0;
        end
        if (run && (insn_we || data_we || data_oe)) n_viol++;
    end

    // memory returns valid data only in the READ_LAT-th cycle of a read
    always @(negedge clk) begin
        data_q = (data_oe && oe_run == READ_LAT - 1) ? env_rd(data_addr) : 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        int w = 0;
        while (!cmd_ready && w < 100) begin
            tick();
            w++;
        end
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_addr  = $urandom;
        cmd_data  = $urandom;
    endtask

    task automatic get_rsp(input string tag, input logic [1:0] est, input logic [31:0] edata,
                           input bit chkd, input int hold);
        int w = 0;
        while (!rsp_valid && w < 300) begin
            tick();
            w++;
        end
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_run_low"}, 32'(run), 32'd0);
        chk({tag, "_core_reset_low"}, 32'(core_reset), 32'd0);
        chk({tag, "_status"}, 32'(rsp_status), 32'(est));
        if (chkd) chk({tag, "_data"}, rsp_data, edata);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_status"}, 32'(rsp_status), 32'(est));
            if (chkd) chk({tag, "_hold_data"}, rsp_data, edata);
            chk({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_back_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_wdata(input logic [31:0] a, input logic [31:0] d, input int hold);
        int b = n_data_we;
        send(WRITE_DATA, a, d);
        data_shadow[a] = d;
        get_rsp("wdata", OK, '0, 1'b0, hold);
        chk("wdata_pulses", 32'(n_data_we - b), 32'd1);
        chk("wdata_mem", env_rd(a), d);
    endtask

    task automatic do_winsn(input logic [31:0] a, input logic [31:0] d, input int hold);
        int b = n_insn_we;
        send(WRITE_INSN, a, d);
        get_rsp("winsn", OK, '0, 1'b1, hold);
        chk("winsn_pulses", 32'(n_insn_we - b), 32'd1);
        chk("winsn_mem", insn_env.exists(a) ? insn_env[a] : 32'hDEAD_0000, d);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold);
        int b = n_data_oe;
        int bw = n_data_we;
        logic [31:0] exp = data_shadow.exists(a) ? data_shadow[a] : dflt(a);
        send(READ_DATA, a, $urandom);
        get_rsp("read", OK, exp, 1'b1, hold);
        chk("read_oe_cycles", 32'(n_data_oe - b), 32'(READ_LAT));
        chk("read_no_we", 32'(n_data_we - bw), 32'd0);
    endtask

    task automatic do_err(input logic [2:0] op, input int hold);
        send(op, $urandom, $urandom);
        get_rsp("err", ERR, '0, 1'b1, hold);
    endtask

    // outcome of a run: first of halt (cycle h), timeout (t), STOP (s) by counter value
    function automatic logic [33:0] model_run(input int t, input int h, input int s);
        for (int c = 0; c < 250; c++) begin
            if (c == h) return {HALT, 32'(c)};
            if (TO_EN && t != 0 && c == t) return {TIMEOUT, 32'(t)};
            if (c == s) return {ABORT, 32'(c)};
        end
        return {OK, 32'd0};
    endfunction

    task automatic do_run(input string tag, input int t, input int h, input int s, input int x,
                          input int hold);
        int rc = 0;
        int c = 0;
        int bs = n_data_we + n_insn_we + n_data_oe;
        logic [33:0] m = model_run(t, h, s);
        send(RUN, $urandom, 32'(t));
        while (core_reset && rc < 40) begin
            rc++;
            tick();
        end
        chk({tag, "_reset_cycles"}, 32'(rc), 32'(RUN_RESET_CYCLES));
        chk({tag, "_run_high"}, 32'(run), 32'd1);
        while (run && c < 250) begin
            halt_mon = (c == h);
            if (c == s || c == x) begin
                chk({tag, "_ready_in_run"}, 32'(cmd_ready), 32'd1);
                cmd_valid = 1'b1;
                cmd_op    = (c == s) ? STOP : WRITE_DATA;
                cmd_addr  = 32'h0000_0010;
                cmd_data  = $urandom;
            end
            tick();
            halt_mon  = 1'b0;
            cmd_valid = 1'b0;
            c++;
        end
        get_rsp(tag, m[33:32], m[31:0], 1'b1, hold);
        chk({tag, "_no_strobes"}, 32'(n_data_we + n_insn_we + n_data_oe - bs), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_strobes", {29'd0, insn_we, data_we, data_oe}, 32'd0);
        chk("rst_data_addr", data_addr, 32'd0);
        chk("rst_insn_din", insn_din, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("rst_core_reset_release", 32'(core_reset), 32'd0);
        chk("rst_idle_ready", 32'(cmd_ready), 32'd1);

        // write then read back
        do_wdata(32'h10, 32'hDEAD_BEEF, 0);
        do_read(32'h10, 0);

        // load a jump-to-self and run until halt after 40 cycles
        do_winsn(32'h0, 32'h0000_006F, 1);
        do_run("halt40", 0, 40, -1, -1, 0);

        // timeout of 100 with halt only at 120 (timeout ignored when disabled)
        do_run("timeout100", 100, 120, -1, -1, 0);

        // halt and STOP together, then STOP alone
        do_run("halt_stop", 0, 10, 10, -1, 0);
        do_run("stop_only", 0, -1, 12, -1, 0);

        // non-STOP command during a run is swallowed
        do_run("junk_in_run", 0, 20, -1, 5, 1);
        chk("junk_no_write", env_rd(32'h10), 32'hDEAD_BEEF);

        // response held back five cycles
        do_read(32'h10, 5);

        // bad opcodes in IDLE
        do_err(STOP, 0);
        do_err(3'd7, 2);

        // asynchronous reset in the middle of a run
        send(RUN, 32'h0, 32'h0);
        repeat (RUN_RESET_CYCLES + 3) tick();
        chk("midrst_running", 32'(run), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_run", 32'(run), 32'd0);
        chk("midrst_core_reset", 32'(core_reset), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_data_addr", data_addr, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("midrst_release", 32'(core_reset), 32'd0);
        repeat (3) tick();
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        chk("midrst_idle", 32'(cmd_ready), 32'd1);

        // randomized traffic
        for (int n = 0; n < 30; n++) begin
            int sel = $urandom_range(0, 6);
            int hold = $urandom_range(0, 3);
            logic [31:0] a = 32'($urandom_range(0, 15));
            int t = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 70);
            case (sel)
                0: do_wdata(a, $urandom, hold);
                1, 6: do_read(a, hold);
                2: do_winsn(a, $urandom, hold);
                3: do_run("rnd_halt", t, $urandom_range(1, 60), -1, -1, hold);
                4: begin
                    int s = $urandom_range(1, 50);
                    if (t == s) t = 0;
                    do_run("rnd_stop", t, -1, s, -1, hold);
                end
                default: do_err(($urandom_range(0, 1) == 0) ? 3'(STOP) : 3'($urandom_range(5, 7)), hold);
            endcase
        end

        chk("no_strobe_while_run", 32'(n_viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
